// File: rtl/mod_counter_fsm.sv
// Modulo up/down counter with an IDLE/RUN/DONE control FSM, wrap or one-shot
// terminal behaviour, clamped synchronous load and a registered terminal pulse.
module mod_counter_fsm #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             running,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             din_in_range;
  logic             at_terminal;

  assign din_in_range = ({1'b0, din} < MOD_EXT);
  assign at_terminal  = up ? (count_q == MAX_VAL) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = din_in_range ? din : MAX_VAL;
      state_d = IDLE;
    end else if (en && (state_q != DONE)) begin
      state_d = RUN;
      if (at_terminal) begin
        tc_d = 1'b1;
        if (oneshot) begin
          state_d = DONE;
        end else begin
          count_d = up ? '0 : MAX_VAL;
        end
      end else begin
        count_d = up ? (count_q + 1'b1) : (count_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign q       = count_q;
  assign tc      = tc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule
